sipo_frame_ctrl: RTL
====================

Name: sipo_frame_ctrl

Overview:
Frame controller that sequences a serial-in/parallel-out shift register. It qualifies incoming serial bits with a strobe and aligns words on a frame-start marker. It counts WIDTH bits per frame and hands each completed word to a downstream consumer over a valid/ready handshake. The block sits between a serial link front end and the parallel datapath, with one output buffer so reception continues while a word waits.

Parameters:
WIDTH, 4, bits per frame / parallel word width; legal range is 2 or more.
TIMEOUT, 16, maximum idle cycles between strobes inside a frame before abort; legal range is 1 or more.

Ports:
clk  input  1  rising-edge clock
clear  input  1  asynchronous active-high reset
din  input  1  serial data bit
din_valid  input  1  bit strobe; din is sampled only when high
frame_start  input  1  qualifies the strobed bit as bit 0 of a new frame
dout  output  WIDTH  completed parallel word; first received bit is at dout[0]
dout_valid  output  1  dout holds an unconsumed word
dout_ready  input  1  consumer accepts dout when dout_valid is also high
busy  output  1  frame reception in progress (state SHIFT)
sync_err  output  1  one-cycle pulse: frame_start arrived mid-frame
overrun  output  1  one-cycle pulse: completed word dropped because the buffer was full
timeout  output  1  one-cycle pulse: frame aborted on strobe gap

Behaviour:
- Reset (clear=1, asynchronous): state=IDLE, shift register=0, bit count=0, gap counter=0, dout=0, and dout_valid, busy, sync_err, overrun and timeout all 0.
- Shift rule: on each accepted bit, the new bit enters the shift register MSB and existing contents shift one place toward the LSB. After WIDTH shifts, the first bit received is at bit 0.
- State IDLE: strobes without frame_start are ignored. A strobe with frame_start shifts the bit in, sets count=1, clears the gap counter and moves to SHIFT.
- State SHIFT, strobe without frame_start: shift the bit in, count=count+1, clear the gap counter.
- State SHIFT, strobe with frame_start: discard the partial word, pulse sync_err, treat this bit as bit 0 (count=1), stay in SHIFT.
- State SHIFT, no strobe: gap counter increments. When it reaches TIMEOUT, pulse timeout, return to IDLE and zero count. The shift register contents are don't-care after an abort.
- Completion: the strobe that brings count to WIDTH completes the frame. The next state is IDLE. The word {din, shreg[WIDTH-1:1]} is offered to the output buffer in the same edge.
- Output buffer loads the completed word if dout_valid=0, or if dout_valid=1 and dout_ready=1 in that cycle (simultaneous consume and load).
  - dout_valid is visible the cycle after the final bit is sampled, giving 1-cycle latency.
  - If the buffer is full and not being consumed, the new word is dropped, overrun pulses, and dout and dout_valid are unchanged.
- Handshake: dout_valid=1 and dout_ready=1 at an edge with no new load clears dout_valid. dout is stable while dout_valid=1 and dout_ready=0. dout_ready is ignored while dout_valid=0.
- busy=1 exactly while state=SHIFT.
- Width rules:
  - count is $clog2(WIDTH+1) bits and never exceeds WIDTH.
  - The gap counter is $clog2(TIMEOUT+1) bits and saturates at TIMEOUT.
- clear asserted mid-frame or with a pending word: everything returns to reset values immediately; the pending word is lost.
- Error pulses are registered and last one cycle. sync_err and overrun cannot both fire on the same edge.

Decomposition:
- Shared package sipo_ctrl_pkg holds:
  - state encoding constants ST_IDLE=1'b0 and ST_SHIFT=1'b1;
  - the count-width and gap-width helper functions.
- Sub-module sipo_shift_en: WIDTH-bit shift register with shift-enable and async clear. It is instantiated once; the FSM, counters and output buffer stay in the top.

Test Plan:
- WIDTH=4, strobes on consecutive cycles with bits 1,0,1,1 and frame_start on the first bit -> cycle after the 4th bit: dout=4'b1101, dout_valid=1, busy=0.
- Same frame with dout_ready=0, then a second frame 0,0,0,1 completes -> overrun pulses once and dout stays 4'b1101. Raising dout_ready then drops dout_valid.
- Two back-to-back frames, dout_ready=1 held on the completion edge of frame 2 -> dout goes 4'b1101 then 4'b1000 with no overrun and no dout_valid gap.
- Bits 1,1 then frame_start with bits 0,1,0,0 -> sync_err pulses on the 3rd strobe; result dout=4'b0010.
- frame_start bit followed by no strobe for 16 cycles -> timeout pulses, busy falls. A following non-start strobe is ignored.
- clear pulsed mid-frame (after 2 bits) and while dout_valid=1 -> all outputs 0 immediately. A fresh full frame then produces the correct word.

Source files
------------

// File: rtl/sipo_ctrl_pkg.sv
// ============================================================================
// Module      : sipo_ctrl_pkg
// Description : Shared state encoding and counter-width helpers for the
//               SIPO frame controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sipo_ctrl_pkg;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_SHIFT = 1'b1;

  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

  function automatic int gap_width(input int timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sipo_shift_en.sv
// ============================================================================
// Module      : sipo_shift_en
// Description : WIDTH-bit shift register; new bits enter at the MSB and move
//               toward the LSB on each enabled cycle. Asynchronous clear.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sipo_shift_en #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             shift_en,
  input  logic             din,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      r_q <= '0;
    end else if (shift_en) begin
      r_q <= {din, r_q[WIDTH-1:1]};
    end
  end

  assign q = r_q;

endmodule

`default_nettype wire

// File: rtl/sipo_frame_ctrl.sv
// ============================================================================
// Module      : sipo_frame_ctrl
// Description : Frames strobed serial bits into WIDTH-bit words and hands
//               them to a valid/ready consumer through a one-word buffer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sipo_frame_ctrl
  import sipo_ctrl_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             din,
  input  logic             din_valid,
  input  logic             frame_start,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             busy,
  output logic             sync_err,
  output logic             overrun,
  output logic             timeout
);

  localparam int c_cnt_w = cnt_width(WIDTH);
  localparam int c_gap_w = gap_width(TIMEOUT);
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(WIDTH - 1);
  localparam logic [c_gap_w-1:0] c_gap_max  = c_gap_w'(TIMEOUT);

  logic               r_state;
  logic               w_state_nxt;
  logic [c_cnt_w-1:0] r_cnt;
  logic [c_cnt_w-1:0] w_cnt_nxt;
  logic [c_gap_w-1:0] r_gap;
  logic [c_gap_w-1:0] w_gap_nxt;
  logic               w_shift_en;
  logic               w_complete;
  logic               w_sync;
  logic               w_to;
  logic               w_load;
  logic               w_overrun;
  logic [WIDTH-1:1]   w_shreg_hi;
  logic               w_unused_lsb;
  logic [WIDTH-1:0]   w_word;

  logic [WIDTH-1:0]   r_dout;
  logic               r_dout_valid;
  logic               r_sync_err;
  logic               r_overrun;
  logic               r_timeout;

  // The register LSB is the bit about to fall out; the completed word is
  // formed from the incoming bit plus the upper taps.
  sipo_shift_en #(
    .WIDTH (WIDTH)
  ) u_shift (
    .clk      (clk),
    .clear    (clear),
    .shift_en (w_shift_en),
    .din      (din),
    .q        ({w_shreg_hi, w_unused_lsb})
  );

  assign w_word = {din, w_shreg_hi};

  // State register
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_gap   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_gap   <= w_gap_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_gap_nxt   = r_gap;
    w_shift_en  = 1'b0;
    w_complete  = 1'b0;
    w_sync      = 1'b0;
    w_to        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (din_valid && frame_start) begin
          w_state_nxt = ST_SHIFT;
          w_cnt_nxt   = c_cnt_one;
          w_gap_nxt   = '0;
          w_shift_en  = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (din_valid) begin
          w_shift_en = 1'b1;
          w_gap_nxt  = '0;
          if (frame_start) begin
            w_sync    = 1'b1;
            w_cnt_nxt = c_cnt_one;
          end else if (r_cnt == c_cnt_last) begin
            w_complete  = 1'b1;
            w_cnt_nxt   = '0;
            w_state_nxt = ST_IDLE;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end else begin
          w_gap_nxt = (r_gap == c_gap_max) ? r_gap : r_gap + 1'b1;
          if (w_gap_nxt == c_gap_max) begin
            w_to        = 1'b1;
            w_cnt_nxt   = '0;
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    busy      = (r_state == ST_SHIFT);
    w_load    = w_complete && (!r_dout_valid || dout_ready);
    w_overrun = w_complete && r_dout_valid && !dout_ready;
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_sync_err   <= 1'b0;
      r_overrun    <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      r_sync_err <= w_sync;
      r_overrun  <= w_overrun;
      r_timeout  <= w_to;
      if (w_load) begin
        r_dout       <= w_word;
        r_dout_valid <= 1'b1;
      end else if (r_dout_valid && dout_ready) begin
        r_dout_valid <= 1'b0;
      end
    end
  end

  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
  assign sync_err   = r_sync_err;
  assign overrun    = r_overrun;
  assign timeout    = r_timeout;

endmodule

`default_nettype wire
